// File: rtl/expr_pkg.sv
// Shared types and constants for the streaming expression recogniser.
package expr_pkg;

    // Recogniser state; codes 3,4,6,7 are unreachable and recover to ERR.
    typedef enum logic [2:0] {
        OPND  = 3'd0,
        NUM   = 3'd1,
        AFTER = 3'd2,
        ERR   = 3'd5
    } state_e;

    // Character classes produced by the classifier.
    typedef enum logic [2:0] {
        C_DIGIT,
        C_OP,
        C_LP,
        C_RP,
        C_WS,
        C_OTHER
    } cls_e;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_SP    = 8'h20;

    localparam logic [1:0] EC_NONE    = 2'd0;
    localparam logic [1:0] EC_ILLEGAL = 2'd1;
    localparam logic [1:0] EC_PAREN   = 2'd2;
    localparam logic [1:0] EC_LONG    = 2'd3;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier; operator set and whitespace handling are
// chosen at elaboration time.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int OP_MODE = 1,
    parameter int SKIP_WS = 1
) (
    input  logic [7:0] in,
    output cls_e       cls
);

    // Map the byte to exactly one class; anything unmatched is C_OTHER.
    always_comb begin
        cls = C_OTHER;
        if (in >= CH_0 && in <= CH_9)
            cls = C_DIGIT;
        else if (in == CH_PLUS || in == CH_STAR)
            cls = C_OP;
        else if ((OP_MODE == 1) && (in == CH_MINUS || in == CH_SLASH))
            cls = C_OP;
        else if (in == CH_LP)
            cls = C_LP;
        else if (in == CH_RP)
            cls = C_RP;
        else if ((SKIP_WS == 1) && in == CH_SP)
            cls = C_WS;
    end

endmodule

// File: rtl/expr_paren_fsm.sv
// Streaming recogniser for infix expressions with multi-digit operands,
// bounded parenthesis nesting and a sticky error code.
module expr_paren_fsm
    import expr_pkg::*;
#(
    parameter int  MAX_DEPTH  = 7,
    parameter int  MAX_DIGITS = 4,
    parameter int  OP_MODE    = 1,
    parameter int  SKIP_WS    = 1,
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1),
    localparam int DIG_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic [2:0]         s,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic [1:0]         err_code
);

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DIG_W-1:0]   dig_q,   dig_d;
    logic [1:0]         code_q,  code_d;
    cls_e               cls;

    expr_char_class #(.OP_MODE(OP_MODE), .SKIP_WS(SKIP_WS)) u_class (
        .in  (in),
        .cls (cls)
    );

    // Next-state: everything holds unless a character is qualified; ERR is sticky.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        dig_d   = dig_q;
        code_d  = code_q;
        if (in_valid) begin
            case (state_q)
                OPND: begin
                    case (cls)
                        C_DIGIT: begin
                            state_d = NUM;
                            dig_d   = DIG_W'(1);
                        end
                        C_LP: begin
                            if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                                state_d = ERR;
                                code_d  = EC_PAREN;
                            end else begin
                                depth_d = depth_q + DEPTH_W'(1);
                            end
                        end
                        C_WS: ;
                        default: begin
                            state_d = ERR;
                            code_d  = EC_ILLEGAL;
                        end
                    endcase
                end
                NUM: begin
                    case (cls)
                        C_DIGIT: begin
                            // Leading zeros count toward the length bound too.
                            if (dig_q == DIG_W'(MAX_DIGITS)) begin
                                state_d = ERR;
                                code_d  = EC_LONG;
                            end else begin
                                dig_d = dig_q + DIG_W'(1);
                            end
                        end
                        C_OP: state_d = OPND;
                        C_RP: begin
                            if (depth_q == '0) begin
                                state_d = ERR;
                                code_d  = EC_PAREN;
                            end else begin
                                depth_d = depth_q - DEPTH_W'(1);
                                state_d = AFTER;
                            end
                        end
                        C_WS: state_d = AFTER;
                        default: begin
                            state_d = ERR;
                            code_d  = EC_ILLEGAL;
                        end
                    endcase
                end
                AFTER: begin
                    case (cls)
                        C_OP: state_d = OPND;
                        C_RP: begin
                            if (depth_q == '0) begin
                                state_d = ERR;
                                code_d  = EC_PAREN;
                            end else begin
                                depth_d = depth_q - DEPTH_W'(1);
                            end
                        end
                        C_WS: ;
                        default: begin
                            state_d = ERR;
                            code_d  = EC_ILLEGAL;
                        end
                    endcase
                end
                ERR: ;
                default: begin
                    state_d = ERR;
                    code_d  = EC_ILLEGAL;
                end
            endcase
        end
    end

    // State register with synchronous clear taking priority over input.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= OPND;
            depth_q <= '0;
            dig_q   <= '0;
            code_q  <= EC_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            dig_q   <= dig_d;
            code_q  <= code_d;
        end
    end

    // Outputs are pure functions of the registers.
    always_comb begin
        s        = state_q;
        depth    = depth_q;
        err      = (state_q == ERR);
        err_code = code_q;
        out      = ((state_q == NUM) || (state_q == AFTER)) && (depth_q == '0);
    end

endmodule

// File: tb/tb_expr_paren_fsm.sv
// Bench: four parameter variants driven by a shared byte stream, checked
// against a tokenising reference model plus table and directed sequences.
module tb_expr_paren_fsm;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;

    logic       out_w  [4];
    logic [2:0] s_w    [4];
    logic [2:0] dep_w  [4];
    logic       err_w  [4];
    logic [1:0] code_w [4];
    logic [1:0] dep1_n;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    // Variant 0: defaults. 1: MAX_DEPTH=2. 2: OP_MODE=0, MAX_DIGITS=2. 3: SKIP_WS=0.
    expr_paren_fsm u0 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_w[0]), .s(s_w[0]), .depth(dep_w[0]), .err(err_w[0]), .err_code(code_w[0]));
    expr_paren_fsm #(.MAX_DEPTH(2)) u1 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_w[1]), .s(s_w[1]), .depth(dep1_n), .err(err_w[1]), .err_code(code_w[1]));
    expr_paren_fsm #(.OP_MODE(0), .MAX_DIGITS(2)) u2 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_w[2]), .s(s_w[2]), .depth(dep_w[2]), .err(err_w[2]), .err_code(code_w[2]));
    expr_paren_fsm #(.SKIP_WS(0)) u3 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_w[3]), .s(s_w[3]), .depth(dep_w[3]), .err(err_w[3]), .err_code(code_w[3]));
    assign dep_w[1] = {1'b0, dep1_n};

    // Reference model: tracks what the grammar expects next, not RTL encoding.
    typedef struct {
        bit failed;
        int code;
        int depth;
        int ndig;
        bit in_number;
        bit operand_done;
    } model_t;

    int P_MAXD  [4] = '{7, 2, 7, 7};
    int P_MAXDG [4] = '{4, 4, 2, 4};
    int P_OPM   [4] = '{1, 1, 0, 1};
    int P_WS    [4] = '{1, 1, 1, 0};
    model_t m [4];

    function automatic model_t m_reset();
        model_t r;
        r.failed = 0; r.code = 0; r.depth = 0; r.ndig = 0;
        r.in_number = 0; r.operand_done = 0;
        return r;
    endfunction

    function automatic model_t m_fail(model_t x, int code);
        model_t r = x;
        r.failed = 1; r.code = code;
        return r;
    endfunction

    function automatic model_t m_step(model_t x, logic [7:0] c, int k);
        model_t r = x;
        bit is_dig = (c >= "0" && c <= "9");
        bit is_op  = (c == "+" || c == "*" || (P_OPM[k] == 1 && (c == "-" || c == "/")));
        bit is_ws  = (P_WS[k] == 1 && c == " ");
        if (x.failed) return x;
        if (is_ws) begin
            if (x.in_number) begin r.in_number = 0; r.operand_done = 1; end
            return r;
        end
        if (is_dig) begin
            if (x.operand_done) return m_fail(x, 1);
            if (x.in_number && x.ndig >= P_MAXDG[k]) return m_fail(x, 3);
            r.ndig = x.in_number ? x.ndig + 1 : 1;
            r.in_number = 1;
            return r;
        end
        if (is_op) begin
            if (!(x.in_number || x.operand_done)) return m_fail(x, 1);
            r.in_number = 0; r.operand_done = 0;
            return r;
        end
        if (c == "(") begin
            if (x.in_number || x.operand_done) return m_fail(x, 1);
            if (x.depth >= P_MAXD[k]) return m_fail(x, 2);
            r.depth = x.depth + 1;
            return r;
        end
        if (c == ")") begin
            if (!(x.in_number || x.operand_done)) return m_fail(x, 1);
            if (x.depth == 0) return m_fail(x, 2);
            r.depth = x.depth - 1; r.in_number = 0; r.operand_done = 1;
            return r;
        end
        return m_fail(x, 1);
    endfunction

    function automatic int m_s(model_t x);
        if (x.failed) return 5;
        if (x.in_number) return 1;
        if (x.operand_done) return 2;
        return 0;
    endfunction

    function automatic int m_out(model_t x);
        return (!x.failed && (x.in_number || x.operand_done) && x.depth == 0) ? 1 : 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_model(string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s u%0d out", tag, k), int'(out_w[k]), m_out(m[k]));
            chk($sformatf("%s u%0d s", tag, k), int'(s_w[k]), m_s(m[k]));
            chk($sformatf("%s u%0d depth", tag, k), int'(dep_w[k]), m[k].depth);
            chk($sformatf("%s u%0d err", tag, k), int'(err_w[k]), int'(m[k].failed));
            chk($sformatf("%s u%0d code", tag, k), int'(code_w[k]), m[k].code);
        end
    endtask

    // One clock: drive between edges, advance the model, sample 1 unit after.
    task automatic drive(logic [7:0] c, bit v, bit r);
        @(negedge clk);
        in = c; in_valid = v; clr = r;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (r) m[k] = m_reset();
            else if (v) m[k] = m_step(m[k], c, k);
        end
        #1;
    endtask

    task automatic feed(string str, string tag);
        for (int i = 0; i < str.len(); i++) begin
            drive(str[i], 1'b1, 1'b0);
            check_model(tag);
        end
    endtask

    typedef struct {
        logic [7:0] ch;
        bit         r;
        int         e_out;
        int         e_s;
        int         e_depth;
        int         e_code;
    } vec_t;
    vec_t tbl[$];

    task automatic add(logic [7:0] ch, bit r, int o, int st, int d, int ec);
        vec_t v;
        v.ch = ch; v.r = r; v.e_out = o; v.e_s = st; v.e_depth = d; v.e_code = ec;
        tbl.push_back(v);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) m[k] = m_reset();

        // Table for the default variant: reset, "12+3", reset, "((7*8)-9)".
        add(8'h00, 1, 0, 0, 0, 0);
        add("1", 0, 1, 1, 0, 0);
        add("2", 0, 1, 1, 0, 0);
        add("+", 0, 0, 0, 0, 0);
        add("3", 0, 1, 1, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0);
        add("(", 0, 0, 0, 1, 0);
        add("(", 0, 0, 0, 2, 0);
        add("7", 0, 0, 1, 2, 0);
        add("*", 0, 0, 0, 2, 0);
        add("8", 0, 0, 1, 2, 0);
        add(")", 0, 0, 2, 1, 0);
        add("-", 0, 0, 0, 1, 0);
        add("9", 0, 0, 1, 1, 0);
        add(")", 0, 1, 2, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ch, !tbl[i].r, tbl[i].r);
            chk($sformatf("tbl%0d out", i), int'(out_w[0]), tbl[i].e_out);
            chk($sformatf("tbl%0d s", i), int'(s_w[0]), tbl[i].e_s);
            chk($sformatf("tbl%0d depth", i), int'(dep_w[0]), tbl[i].e_depth);
            chk($sformatf("tbl%0d code", i), int'(code_w[0]), tbl[i].e_code);
            check_model($sformatf("tbl%0d", i));
        end

        // Depth overflow on the MAX_DEPTH=2 variant; ERR then ignores "1)".
        drive(8'h00, 1'b0, 1'b1);
        feed("(((", "ovf");
        chk("ovf s", int'(s_w[1]), 5);
        chk("ovf code", int'(code_w[1]), 2);
        chk("ovf depth", int'(dep_w[1]), 2);
        feed("1)", "ovf_post");
        chk("ovf sticky s", int'(s_w[1]), 5);
        chk("ovf sticky depth", int'(dep_w[1]), 2);

        // Operand length bound.
        drive(8'h00, 1'b0, 1'b1);
        feed("1234", "len");
        chk("len out at 4", int'(out_w[0]), 1);
        feed("5", "len5");
        chk("len out at 5", int'(out_w[0]), 0);
        chk("len code", int'(code_w[0]), 3);

        // Operator set selection.
        drive(8'h00, 1'b0, 1'b1);
        feed("4-2", "opm");
        chk("opm0 code", int'(code_w[2]), 1);
        chk("opm0 s", int'(s_w[2]), 5);
        chk("opm1 out", int'(out_w[0]), 1);

        // Qualified feed with junk bytes on idle cycles.
        drive(8'h00, 1'b0, 1'b1);
        begin
            string str = "1 + 2";
            for (int i = 0; i < str.len(); i++) begin
                drive(str[i], 1'b1, 1'b0);
                check_model("tog");
                drive("x", 1'b0, 1'b0);
                check_model("tog_idle");
            end
        end
        chk("tog out", int'(out_w[0]), 1);
        chk("tog ws0 code", int'(code_w[3]), 1);

        // Two operands separated only by whitespace.
        drive(8'h00, 1'b0, 1'b1);
        feed("1 2", "sp");
        chk("sp s", int'(s_w[0]), 5);
        chk("sp code", int'(code_w[0]), 1);

        // Whitespace alone never completes an expression.
        drive(8'h00, 1'b0, 1'b1);
        feed("  ", "wsonly");
        chk("wsonly out", int'(out_w[0]), 0);

        // Clear mid-string, with a valid char on the same edge.
        drive(8'h00, 1'b0, 1'b1);
        feed("(3+", "mid");
        drive("7", 1'b1, 1'b1);
        chk("clr s", int'(s_w[0]), 0);
        chk("clr depth", int'(dep_w[0]), 0);
        chk("clr out", int'(out_w[0]), 0);
        chk("clr err", int'(err_w[0]), 0);
        chk("clr code", int'(code_w[0]), 0);

        // Random stream against the model.
        begin
            string alpha = "0123456789+-*/()()(( x)";
            for (int i = 0; i < 3000; i++) begin
                logic [7:0] c = alpha[$urandom_range(0, alpha.len() - 1)];
                bit v = ($urandom_range(0, 3) != 0);
                bit r = ($urandom_range(0, 24) == 0);
                drive(c, v, r);
                check_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
